// File: rtl/src_pkg.sv
// Shared definitions for the SRC datapath: data width, ALU op-select enum
// and the fixed-priority encoder that turns one-hot op strobes into an op.
package src_pkg;

  localparam int SRC_WIDTH   = 32;
  localparam int SRC_SHAMT_W = 5;
  localparam int SRC_NUM_OPS = 10;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    AND   = 4'd2,
    OR    = 4'd3,
    SHR   = 4'd4,
    SHRA  = 4'd5,
    SHL   = 4'd6,
    NOT   = 4'd7,
    PASSB = 4'd8,
    INC4  = 4'd9,
    NONE  = 4'd10
  } alu_op_e;

  // Strobe vector layout, MSB first: add, sub, a_and_b, a_or_b, shr, shra,
  // shl, not_a, c_eq_b, inc_4. The MSB wins when several are asserted.
  function automatic alu_op_e prio_encode(input logic [SRC_NUM_OPS-1:0] strobes);
    alu_op_e op;
    op = NONE;
    if      (strobes[9]) op = ADD;
    else if (strobes[8]) op = SUB;
    else if (strobes[7]) op = AND;
    else if (strobes[6]) op = OR;
    else if (strobes[5]) op = SHR;
    else if (strobes[4]) op = SHRA;
    else if (strobes[3]) op = SHL;
    else if (strobes[2]) op = NOT;
    else if (strobes[1]) op = PASSB;
    else if (strobes[0]) op = INC4;
    return op;
  endfunction

endpackage

// File: rtl/src_alu_core.sv
// Purely combinational SRC ALU function: (op, A, B) -> result.
// Arithmetic wraps modulo 2^WIDTH; shifts use only B[SHAMT_W-1:0].
module src_alu_core
  import src_pkg::*;
#(
  parameter int WIDTH   = SRC_WIDTH,
  parameter int SHAMT_W = SRC_SHAMT_W
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  // Select the operation; NONE yields zero but is never captured into C.
  always_comb begin
    result = '0;
    case (op)
      ADD:     result = a + b;
      SUB:     result = a - b;
      AND:     result = a & b;
      OR:      result = a | b;
      SHR:     result = a >> shamt;
      SHRA:    result = $signed(a) >>> shamt;
      SHL:     result = a << shamt;
      NOT:     result = ~a;
      PASSB:   result = b;
      INC4:    result = b + WIDTH'(4);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/src_alu.sv
// SRC single-bus ALU: A operand register, C result register and the C
// tri-state driver onto cpu_bus. B is whatever is on cpu_bus this cycle,
// so when C itself drives the bus, B is the old C.
// Optional build macro: SRC_ALU_FLAGS_EN adds registered zero/negative
// flags (flag_z, flag_n) that load together with C.
module src_alu
  import src_pkg::*;
#(
  parameter int WIDTH   = SRC_WIDTH,
  parameter int SHAMT_W = SRC_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] cpu_bus,
  input  logic             a_in,
  input  logic             c_in,
  input  logic             add,
  input  logic             sub,
  input  logic             a_and_b,
  input  logic             a_or_b,
  input  logic             shr,
  input  logic             shra,
  input  logic             shl,
  input  logic             not_a,
  input  logic             c_eq_b,
  input  logic             inc_4,
`ifdef SRC_ALU_FLAGS_EN
  output logic             flag_z,
  output logic             flag_n,
`endif
  input  logic             c_out
);

  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       c_q;
  logic [WIDTH-1:0]       result;
  logic [SRC_NUM_OPS-1:0] strobes;
  alu_op_e                op;
  logic                   c_load;

  assign strobes = {add, sub, a_and_b, a_or_b, shr, shra, shl, not_a, c_eq_b, inc_4};
  assign op      = prio_encode(strobes);
  // c_in with no op strobe leaves C (and flags) untouched.
  assign c_load  = c_in && (op != NONE);

  src_alu_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .op     (op),
    .a      (a_q),
    .b      (cpu_bus),
    .result (result)
  );

  // Drive C onto the shared bus only while c_out is high, reset included.
  assign cpu_bus = c_out ? c_q : 'z;

  // A captures the bus; with c_out high this is a C->A move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
    end else if (a_in) begin
      a_q <= cpu_bus;
    end
  end

  // C captures the ALU result computed from the pre-edge A and bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
    end else if (c_load) begin
      c_q <= result;
    end
  end

`ifdef SRC_ALU_FLAGS_EN
  // Zero/negative flags track every C load and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (c_load) begin
      flag_z <= (result == '0);
      flag_n <= result[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_src_alu.sv
// Directed testbench for src_alu. C is observed by driving it onto the bus;
// A is observed indirectly through ADD with B=0. Bus release is observed by
// the bench driving zero: any stray C drive would corrupt the read value.
`timescale 1ns/1ps
module tb_src_alu;

  localparam int W = 32;

  localparam logic [9:0] S_NONE = 10'b00_0000_0000;
  localparam logic [9:0] S_ADD  = 10'b10_0000_0000;
  localparam logic [9:0] S_SUB  = 10'b01_0000_0000;
  localparam logic [9:0] S_AND  = 10'b00_1000_0000;
  localparam logic [9:0] S_OR   = 10'b00_0100_0000;
  localparam logic [9:0] S_SHR  = 10'b00_0010_0000;
  localparam logic [9:0] S_SHRA = 10'b00_0001_0000;
  localparam logic [9:0] S_SHL  = 10'b00_0000_1000;
  localparam logic [9:0] S_NOT  = 10'b00_0000_0100;
  localparam logic [9:0] S_PASS = 10'b00_0000_0010;
  localparam logic [9:0] S_INC4 = 10'b00_0000_0001;

  logic clk = 1'b0;
  logic rst_n;
  logic a_in, c_in, c_out;
  logic add, sub, a_and_b, a_or_b, shr, shra, shl, not_a, c_eq_b, inc_4;
  logic         tb_en;
  logic [W-1:0] tb_drv;
  wire  [W-1:0] cpu_bus;
`ifdef SRC_ALU_FLAGS_EN
  logic flag_z, flag_n;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  assign cpu_bus = tb_en ? tb_drv : 'z;

  src_alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_bus (cpu_bus),
    .a_in    (a_in),
    .c_in    (c_in),
    .add     (add),
    .sub     (sub),
    .a_and_b (a_and_b),
    .a_or_b  (a_or_b),
    .shr     (shr),
    .shra    (shra),
    .shl     (shl),
    .not_a   (not_a),
    .c_eq_b  (c_eq_b),
    .inc_4   (inc_4),
`ifdef SRC_ALU_FLAGS_EN
    .flag_z  (flag_z),
    .flag_n  (flag_n),
`endif
    .c_out   (c_out)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: apply one cycle of controls at negedge, release after posedge.
  task automatic op_cycle(input logic drv, input logic [W-1:0] val, input logic [9:0] st,
                          input logic la, input logic lc, input logic co);
    @(negedge clk);
    tb_en  = drv;
    tb_drv = val;
    {add, sub, a_and_b, a_or_b, shr, shra, shl, not_a, c_eq_b, inc_4} = st;
    a_in   = la;
    c_in   = lc;
    c_out  = co;
    @(posedge clk);
    #1;
    tb_en  = 1'b0;
    {add, sub, a_and_b, a_or_b, shr, shra, shl, not_a, c_eq_b, inc_4} = S_NONE;
    a_in   = 1'b0;
    c_in   = 1'b0;
    c_out  = 1'b0;
  endtask

  task automatic load_a(input logic [W-1:0] v);
    op_cycle(1'b1, v, S_NONE, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [W-1:0] b, input logic [9:0] st);
    op_cycle(1'b1, b, st, 1'b0, 1'b1, 1'b0);
  endtask

  // Scoreboard: expected C values are queued, then popped when C is read.
  task automatic expect_c(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic read_c(input string tag);
    logic [W-1:0] exp;
    @(negedge clk);
    tb_en = 1'b0;
    c_out = 1'b1;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got=empty_queue exp=entry", tag);
    end else begin
      exp = exp_q.pop_front();
      check(tag, cpu_bus, exp);
    end
    c_out = 1'b0;
  endtask

  // A is read out as A + 0 into C.
  task automatic read_a(input string tag, input logic [W-1:0] v);
    alu('0, S_ADD);
    expect_c(v);
    read_c(tag);
  endtask

  task automatic check_flags(input string tag, input logic z, input logic n);
`ifdef SRC_ALU_FLAGS_EN
    check(tag, {30'd0, flag_n, flag_z}, {30'd0, n, z});
`else
    if (z === 1'bx || n === 1'bx) $display("note %s", tag);
`endif
  endtask

  initial begin
    rst_n  = 1'b0;
    tb_en  = 1'b0;
    tb_drv = '0;
    a_in   = 1'b0;
    c_in   = 1'b0;
    c_out  = 1'b0;
    {add, sub, a_and_b, a_or_b, shr, shra, shl, not_a, c_eq_b, inc_4} = S_NONE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Reset: preload A and C, then assert reset mid-cycle
    load_a(32'h0000_0077);
    alu(32'h0000_0055, S_PASS);
    expect_c(32'h0000_0055);
    read_c("pre_reset_c");
    @(negedge clk);
    tb_en  = 1'b1;
    tb_drv = '0;
    c_out  = 1'b0;
    #1;
    check("bus_released_idle", cpu_bus, '0);
    tb_en = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    c_out = 1'b1;
    #1;
    check("reset_c_async", cpu_bus, '0);
    check_flags("reset_flags", 1'b0, 1'b0);
    c_out = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    alu(32'h0000_0001, S_ADD);
    expect_c(32'h0000_0001);
    read_c("reset_a_zero");

    // 2. Add wrap and subtract wrap
    load_a(32'hFFFF_FFFF);
    alu(32'h0000_0001, S_ADD);
    check_flags("add_wrap_flags", 1'b1, 1'b0);
    expect_c(32'h0000_0000);
    read_c("add_wrap");
    load_a(32'h0000_0000);
    alu(32'h0000_0001, S_SUB);
    check_flags("sub_wrap_flags", 1'b0, 1'b1);
    expect_c(32'hFFFF_FFFF);
    read_c("sub_wrap");

    // 3. Shifts, including zero amount and ignored high bits of B
    load_a(32'h8000_0000);
    alu(32'h0000_0004, S_SHR);
    expect_c(32'h0800_0000);
    read_c("shr_4");
    alu(32'h0000_0004, S_SHRA);
    expect_c(32'hF800_0000);
    read_c("shra_4");
    alu(32'h0000_0004, S_SHL);
    expect_c(32'h0000_0000);
    read_c("shl_4");
    alu(32'h0000_0020, S_SHR);
    expect_c(32'h8000_0000);
    read_c("shr_amt0");
    alu(32'hFFFF_FFE4, S_SHRA);
    expect_c(32'hF800_0000);
    read_c("shra_hi_ignored");

    // Logic ops
    load_a(32'hF0F0_00FF);
    alu(32'h0FF0_0F0F, S_AND);
    expect_c(32'h00F0_000F);
    read_c("and");
    alu(32'h0FF0_0F0F, S_OR);
    expect_c(32'hFFF0_0FFF);
    read_c("or");
    alu(32'h1234_5678, S_NOT);
    expect_c(32'h0F0F_FF00);
    read_c("not_a");

    // 4. inc_4 / c_eq_b leave A alone
    load_a(32'h0000_0055);
    alu(32'h0000_0010, S_INC4);
    expect_c(32'h0000_0014);
    read_c("inc4");
    alu(32'h0000_1234, S_PASS);
    expect_c(32'h0000_1234);
    read_c("pass_b");
    read_a("a_untouched", 32'h0000_0055);
    alu(32'hFFFF_FFFC, S_INC4);
    check_flags("inc4_wrap_flags", 1'b1, 1'b0);
    expect_c(32'h0000_0000);
    read_c("inc4_wrap");

    // 5. Priority, no-op c_in, strobes without c_in
    load_a(32'h0000_0005);
    alu(32'h0000_0003, S_ADD | S_SUB);
    expect_c(32'h0000_0008);
    read_c("prio_add_sub");
    alu(32'h0000_0003, S_NONE);
    check_flags("noop_flags_hold", 1'b0, 1'b0);
    expect_c(32'h0000_0008);
    read_c("noop_hold");
    op_cycle(1'b1, 32'h0000_0003, S_SUB, 1'b0, 1'b0, 1'b0);
    expect_c(32'h0000_0008);
    read_c("strobe_no_cin");
    alu(32'h0000_0003, S_SUB | S_AND | S_INC4);
    expect_c(32'h0000_0002);
    read_c("prio_sub_and");
    alu(32'h0000_0003, S_SHL | S_NOT | S_PASS);
    expect_c(32'h0000_0028);
    read_c("prio_shl_not");

    // a_in and c_in together: C uses the old A
    load_a(32'h0000_000A);
    op_cycle(1'b1, 32'h0000_0007, S_ADD, 1'b1, 1'b1, 1'b0);
    expect_c(32'h0000_0011);
    read_c("ain_cin_old_a");
    read_a("ain_cin_new_a", 32'h0000_0007);

    // c_out and c_in together: B is the old C
    load_a(32'h0000_0003);
    alu(32'h0000_0100, S_PASS);
    op_cycle(1'b0, '0, S_ADD, 1'b0, 1'b1, 1'b1);
    expect_c(32'h0000_0103);
    read_c("cout_cin_old_c");

    // 6. C->A move and same-cycle bus release
    alu(32'hDEAD_0000, S_PASS);
    op_cycle(1'b0, '0, S_NONE, 1'b1, 1'b0, 1'b1);
    alu(32'h0000_0000, S_PASS);
    read_a("c_to_a_move", 32'hDEAD_0000);
    alu(32'hDEAD_0000, S_PASS);
    @(negedge clk);
    c_out = 1'b1;
    #2;
    c_out  = 1'b0;
    tb_en  = 1'b1;
    tb_drv = '0;
    #1;
    check("turnaround_release", cpu_bus, '0);
    tb_en = 1'b0;

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
